// File: rtl/checkpoint_scoreboard.sv
// Self-check monitor: in-order checkpoint scoring, guard window, hang watchdog.
// Optional SCB_DISPLAY_EN adds simulation-only progress and summary messages.
module checkpoint_scoreboard #(
  parameter int          NUM_CKPT    = 39,
  parameter logic [31:0] PASS_VAL    = 32'h1,
  parameter logic [31:0] START_PC    = 32'h0004,
  parameter logic [31:0] END_PC      = 32'h1680,
  parameter int          TIMEOUT_CYC = 100000,
  parameter int          CW          = $clog2(NUM_CKPT + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [31:0]             o_pc_debug,
  input  logic                    o_insn_vld,
  input  logic [31:0]             o_io_ledr,
  input  logic [NUM_CKPT*32-1:0]  i_ckpt_pc,
  input  logic [31:0]             i_guard_lo,
  input  logic [31:0]             i_guard_hi,
  output logic [1:0]              o_sb_state,
  output logic [CW-1:0]           o_sb_idx,
  output logic [CW-1:0]           o_sb_pass,
  output logic [CW-1:0]           o_sb_fail,
  output logic [NUM_CKPT-1:0]     o_sb_mask,
  output logic                    o_sb_order,
  output logic                    o_sb_guard,
  output logic                    o_sb_done,
  output logic                    o_sb_ok
);

  // state     | meaning
  // S_IDLE    | waiting for START_PC to retire
  // S_RUN     | scoring checkpoints, guard and watchdog active
  // S_DONE    | END_PC retired, results frozen
  // S_TIMEOUT | no retirement within TIMEOUT_CYC cycles, results frozen
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_TIMEOUT = 2'd3} state_t;

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [WW-1:0] ONE_W   = WW'(1);
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] IDX_END = CW'(NUM_CKPT);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_idx, w_idx_nxt;
  logic [CW-1:0]         r_pass, w_pass_nxt;
  logic [CW-1:0]         r_fail, w_fail_nxt;
  logic [NUM_CKPT-1:0]   r_mask, w_mask_nxt;
  logic                  r_order, w_order_nxt;
  logic                  r_guard, w_guard_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ok, w_ok_nxt;
  logic [WW-1:0]         r_wdog, w_wdog_nxt;
  logic                  w_cur_hit, w_other_hit, w_in_guard, w_ledr_ok;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_mask  <= '0;
      r_order <= 1'b0;
      r_guard <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
      r_mask  <= w_mask_nxt;
      r_order <= w_order_nxt;
      r_guard <= w_guard_nxt;
      r_done  <= w_done_nxt;
      r_ok    <= w_ok_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail;
    w_mask_nxt  = r_mask;
    w_order_nxt = r_order;
    w_guard_nxt = r_guard;
    w_wdog_nxt  = r_wdog;
    w_cur_hit   = 1'b0;
    w_other_hit = 1'b0;
    w_in_guard  = (o_pc_debug >= i_guard_lo) && (o_pc_debug <= i_guard_hi);
    w_ledr_ok   = (o_io_ledr == PASS_VAL);

    // Strictly increasing table: at most one entry can match the PC.
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (o_pc_debug == i_ckpt_pc[32*j +: 32]) begin
        if (r_idx == CW'(j)) w_cur_hit = 1'b1;
        else                 w_other_hit = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (o_insn_vld && o_pc_debug == START_PC) begin
          w_state_nxt = S_RUN;
          w_wdog_nxt  = WD_LOAD;
        end
      end
      S_RUN: begin
        if (o_insn_vld) begin
          w_wdog_nxt = WD_LOAD;
          if (o_pc_debug == END_PC) w_state_nxt = S_DONE;
          if (w_cur_hit) begin
            w_idx_nxt = r_idx + ONE_C;
            if (w_ledr_ok) begin
              w_pass_nxt = r_pass + ONE_C;
              for (int j = 0; j < NUM_CKPT; j++)
                if (r_idx == CW'(j)) w_mask_nxt[j] = 1'b1;
            end else begin
              w_fail_nxt = r_fail + ONE_C;
            end
          end
          if (w_other_hit) w_order_nxt = 1'b1;
          if (w_in_guard)  w_guard_nxt = 1'b1;
        end else if (r_wdog == '0) begin
          w_state_nxt = S_TIMEOUT;
        end else begin
          w_wdog_nxt = r_wdog - ONE_W;
        end
      end
      default: ;
    endcase

    w_done_nxt = (w_state_nxt == S_DONE) || (w_state_nxt == S_TIMEOUT);
    w_ok_nxt   = (w_state_nxt == S_DONE) && (w_idx_nxt == IDX_END) && (w_fail_nxt == '0)
                 && !w_order_nxt && !w_guard_nxt;
  end

  assign o_sb_state = r_state;
  assign o_sb_idx   = r_idx;
  assign o_sb_pass  = r_pass;
  assign o_sb_fail  = r_fail;
  assign o_sb_mask  = r_mask;
  assign o_sb_order = r_order;
  assign o_sb_guard = r_guard;
  assign o_sb_done  = r_done;
  assign o_sb_ok    = r_ok;

`ifdef SCB_DISPLAY_EN
  always @(posedge i_clk) begin
    if (!i_reset && r_state == S_RUN) begin
      if (o_insn_vld && w_cur_hit)
        $write("[%0t]::%0d::%s\n", $time, r_idx, w_ledr_ok ? "PASSED" : "FAILED");
      if (w_order_nxt && !r_order)
        $display("[%0t] checkpoint retired out of order, pc=%h", $time, o_pc_debug);
      if (w_guard_nxt && !r_guard)
        $display("[%0t] retirement inside guard window, pc=%h", $time, o_pc_debug);
      if (w_done_nxt)
        $display("pass=%0d fail=%0d ok=%0b", w_pass_nxt, w_fail_nxt, w_ok_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_checkpoint_scoreboard.sv
// Directed bench for checkpoint_scoreboard: 4 checkpoints {10,20,30,40}, END_PC=50, timeout 16.
module tb_checkpoint_scoreboard;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic [31:0]     o_pc_debug = '0;
  logic            o_insn_vld = 1'b0;
  logic [31:0]     o_io_ledr = '0;
  logic [N*32-1:0] i_ckpt_pc;
  logic [31:0]     i_guard_lo = 32'd1;
  logic [31:0]     i_guard_hi = 32'd0;
  logic [1:0]      o_sb_state;
  logic [CW-1:0]   o_sb_idx, o_sb_pass, o_sb_fail;
  logic [N-1:0]    o_sb_mask;
  logic            o_sb_order, o_sb_guard, o_sb_done, o_sb_ok;

  int n_total = 0;
  int n_pass  = 0;

  assign i_ckpt_pc = {32'd40, 32'd30, 32'd20, 32'd10};

  checkpoint_scoreboard #(
    .NUM_CKPT(N), .PASS_VAL(32'h1), .START_PC(32'd4), .END_PC(32'd50), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_pc_debug(o_pc_debug), .o_insn_vld(o_insn_vld),
    .o_io_ledr(o_io_ledr), .i_ckpt_pc(i_ckpt_pc), .i_guard_lo(i_guard_lo), .i_guard_hi(i_guard_hi),
    .o_sb_state(o_sb_state), .o_sb_idx(o_sb_idx), .o_sb_pass(o_sb_pass), .o_sb_fail(o_sb_fail),
    .o_sb_mask(o_sb_mask), .o_sb_order(o_sb_order), .o_sb_guard(o_sb_guard),
    .o_sb_done(o_sb_done), .o_sb_ok(o_sb_ok)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle on the falling edge, then sample just after the rising edge.
  task automatic step(input logic [31:0] pc, input logic vld, input logic [31:0] ledr);
    @(negedge i_clk);
    o_pc_debug = pc;
    o_insn_vld = vld;
    o_io_ledr  = ledr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset    = 1'b1;
    o_insn_vld = 1'b0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(o_sb_state), 32'd0);
    chk({tag, "_idx"},   32'(o_sb_idx),   32'd0);
    chk({tag, "_pass"},  32'(o_sb_pass),  32'd0);
    chk({tag, "_fail"},  32'(o_sb_fail),  32'd0);
    chk({tag, "_mask"},  32'(o_sb_mask),  32'd0);
    chk({tag, "_flags"}, {28'd0, o_sb_order, o_sb_guard, o_sb_done, o_sb_ok}, 32'd0);
  endtask

  initial begin
    // Test 1: clean run
    do_reset();
    chk_all_zero("reset");
    step(32'd10, 1'b1, 32'd1);
    chk("t1_idle_ignores_ckpt", 32'(o_sb_idx), 32'd0);
    step(32'd4, 1'b1, 32'd1);
    chk("t1_run", 32'(o_sb_state), 32'd1);
    step(32'd10, 1'b1, 32'd1);
    chk("t1_idx1", 32'(o_sb_idx), 32'd1);
    chk("t1_mask1", 32'(o_sb_mask), 32'h1);
    step(32'd20, 1'b1, 32'd1);
    step(32'd30, 1'b1, 32'd1);
    step(32'd40, 1'b1, 32'd1);
    chk("t1_pass4", 32'(o_sb_pass), 32'd4);
    chk("t1_not_done", 32'(o_sb_done), 32'd0);
    step(32'd50, 1'b1, 32'd1);
    chk("t1_state_done", 32'(o_sb_state), 32'd2);
    chk("t1_mask", 32'(o_sb_mask), 32'hF);
    chk("t1_fail", 32'(o_sb_fail), 32'd0);
    chk("t1_done", 32'(o_sb_done), 32'd1);
    chk("t1_ok", 32'(o_sb_ok), 32'd1);
    step(32'd10, 1'b1, 32'd0);
    chk("t1_frozen_fail", 32'(o_sb_fail), 32'd0);
    chk("t1_frozen_order", 32'(o_sb_order), 32'd0);

    // Test 2: LEDR=0 at checkpoint 30
    do_reset();
    step(32'd4, 1'b1, 32'd1);
    step(32'd10, 1'b1, 32'd1);
    step(32'd20, 1'b1, 32'd1);
    step(32'd30, 1'b1, 32'd0);
    step(32'd40, 1'b1, 32'd1);
    step(32'd50, 1'b1, 32'd1);
    chk("t2_pass", 32'(o_sb_pass), 32'd3);
    chk("t2_fail", 32'(o_sb_fail), 32'd1);
    chk("t2_mask", 32'(o_sb_mask), 32'hB);
    chk("t2_done", 32'(o_sb_done), 32'd1);
    chk("t2_ok", 32'(o_sb_ok), 32'd0);

    // Test 3: stalled PC scored once; invalid retirement ignored
    do_reset();
    step(32'd4, 1'b1, 32'd1);
    step(32'd10, 1'b1, 32'd1);
    for (int i = 0; i < 5; i++) step(32'd20, 1'b1, 32'd1);
    chk("t3_idx_stall", 32'(o_sb_idx), 32'd2);
    chk("t3_pass_stall", 32'(o_sb_pass), 32'd2);
    step(32'd30, 1'b0, 32'd1);
    chk("t3_idx_novld", 32'(o_sb_idx), 32'd2);
    step(32'd30, 1'b1, 32'd1);
    chk("t3_idx_vld", 32'(o_sb_idx), 32'd3);

    // Test 4: out-of-order checkpoint
    do_reset();
    step(32'd4, 1'b1, 32'd1);
    step(32'd10, 1'b1, 32'd1);
    step(32'd30, 1'b1, 32'd1);
    chk("t4_order", 32'(o_sb_order), 32'd1);
    chk("t4_idx", 32'(o_sb_idx), 32'd1);
    step(32'd20, 1'b1, 32'd1);
    step(32'd30, 1'b1, 32'd1);
    step(32'd40, 1'b1, 32'd1);
    step(32'd50, 1'b1, 32'd1);
    chk("t4_pass", 32'(o_sb_pass), 32'd4);
    chk("t4_state", 32'(o_sb_state), 32'd2);
    chk("t4_ok", 32'(o_sb_ok), 32'd0);

    // Test 5: guard window [60,70]
    do_reset();
    i_guard_lo = 32'd60;
    i_guard_hi = 32'd70;
    step(32'd4, 1'b1, 32'd1);
    step(32'd59, 1'b1, 32'd1);
    chk("t5_guard_below", 32'(o_sb_guard), 32'd0);
    step(32'd64, 1'b0, 32'd1);
    chk("t5_guard_novld", 32'(o_sb_guard), 32'd0);
    step(32'd64, 1'b1, 32'd1);
    chk("t5_guard_set", 32'(o_sb_guard), 32'd1);
    step(32'd10, 1'b1, 32'd1);
    step(32'd20, 1'b1, 32'd1);
    step(32'd30, 1'b1, 32'd1);
    step(32'd40, 1'b1, 32'd1);
    step(32'd50, 1'b1, 32'd1);
    chk("t5_pass", 32'(o_sb_pass), 32'd4);
    chk("t5_done", 32'(o_sb_done), 32'd1);
    chk("t5_ok", 32'(o_sb_ok), 32'd0);
    i_guard_lo = 32'd1;
    i_guard_hi = 32'd0;

    // Test 6: watchdog, then reset clears everything
    do_reset();
    step(32'd4, 1'b1, 32'd1);
    step(32'd10, 1'b1, 32'd1);
    step(32'd20, 1'b1, 32'd1);
    for (int i = 0; i < 15; i++) step(32'd0, 1'b0, 32'd0);
    chk("t6_run_at_15", 32'(o_sb_state), 32'd1);
    step(32'd0, 1'b0, 32'd0);
    chk("t6_timeout_at_16", 32'(o_sb_state), 32'd3);
    chk("t6_done", 32'(o_sb_done), 32'd1);
    chk("t6_ok", 32'(o_sb_ok), 32'd0);
    chk("t6_pass_frozen", 32'(o_sb_pass), 32'd2);
    step(32'd30, 1'b1, 32'd1);
    chk("t6_absorbing", 32'(o_sb_state), 32'd3);
    do_reset();
    chk_all_zero("t6_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
